sram_access_arbiter: RTL and testbench

//   Shares the single asynchronous SRAM between two requesters: the CPU control path (port A)
//   and a program loader / debug port (port B). Sequences each access as a fixed multi-cycle

---
 rtl/sram_access_arbiter.sv | 125 ++++++++++++
 tb/tb_sram_access_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between two requesters.
// Each access holds the strobes for ACCESS_CYCLES cycles, then pulses the owner's done.
module sram_access_arbiter #(
    parameter int unsigned ADDR_W        = 20,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ACCESS_CYCLES = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in
);

    localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            rr_q;     // 0: A wins a tie, 1: B wins a tie
    logic            owner_q;  // 0: A, 1: B
    logic            we_q;
    logic            any_req;
    logic            grant_b;
    logic            last_cycle;

    assign any_req    = a_req | b_req;
    assign grant_b    = b_req & (~a_req | rr_q);
    assign last_cycle = (cnt_q == CntW'(ACCESS_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req) state_d = StAccess;
            StAccess: if (last_cycle) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        a_done     = 1'b0;
        b_done     = 1'b0;
        busy       = (state_q != StIdle);
        unique case (state_q)
            StAccess: begin
                sram_ce_n  = 1'b0;
                sram_oe_n  = we_q;
                sram_we_n  = ~we_q;
                sram_dq_oe = we_q;
            end
            StDone: begin
                a_done = ~owner_q;
                b_done = owner_q;
            end
            default: ;
        endcase
    end

    // Grant capture, access counter, read-data return and round-robin update.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            a_rdata     <= '0;
            b_rdata     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        owner_q     <= grant_b;
                        we_q        <= grant_b ? b_we : a_we;
                        sram_addr   <= grant_b ? b_addr : a_addr;
                        sram_dq_out <= grant_b ? b_wdata : a_wdata;
                        cnt_q       <= '0;
                    end
                end
                StAccess: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (last_cycle && !we_q) begin
                        if (owner_q) b_rdata <= sram_dq_in;
                        else         a_rdata <= sram_dq_in;
                    end
                end
                StDone:  rr_q <= ~owner_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Randomised and directed bench for sram_access_arbiter with an SRAM model and a
// per-port scoreboard of expected completions.
module tb_sram_access_arbiter;

    localparam int unsigned ADDR_W        = 20;
    localparam int unsigned DATA_W        = 16;
    localparam int unsigned ACCESS_CYCLES = 3;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
    logic              a_done, b_done, busy;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_out;
    logic [DATA_W-1:0] sram_dq_in = '0;

    sram_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(ACCESS_CYCLES)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_done(b_done), .b_rdata(b_rdata),
        .busy(busy), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } item_t;

    item_t             q_a[$];
    item_t             q_b[$];
    item_t             mon_it;
    logic [DATA_W-1:0] ref_mem[logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] sram_mem[logic [ADDR_W-1:0]];
    int n_cmp = 0;
    int n_fail = 0;

    // Activity counters and capture used by directed checks.
    int oe_lo = 0, we_lo = 0, dqoe_hi = 0, a_done_cnt = 0, b_done_cnt = 0, wcnt = 0;
    logic [DATA_W-1:0] last_wdata = '0;

    function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    function automatic logic [DATA_W-1:0] sram_rd(input logic [ADDR_W-1:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
    endfunction

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // SRAM model: a write lands only after a full-width write pulse.
    always @(negedge Clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            wcnt++;
            we_lo++;
            last_wdata = sram_dq_out;
            if (wcnt == ACCESS_CYCLES)
                sram_mem[sram_addr] = sram_dq_oe ? sram_dq_out : 16'hxxxx;
        end else begin
            wcnt = 0;
        end
        if (!sram_oe_n) oe_lo++;
        if (sram_dq_oe) dqoe_hi++;
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
        sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_rd(sram_addr) : '0;
        check("oe_we_overlap", 32'(!sram_oe_n && !sram_we_n), 32'd0);
        check("dq_oe_while_oe", 32'(sram_dq_oe && !sram_oe_n), 32'd0);
        check("double_done", 32'(a_done && b_done), 32'd0);
    end

    // Scoreboard monitor.
    always @(negedge Clk) begin
        if (a_done) begin
            if (q_a.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL a_unexpected_done: got done expected none (cycle %0d)", cyc);
            end else begin
                mon_it = q_a.pop_front();
                if (mon_it.we) check("a_write_mem", 32'(sram_rd(mon_it.addr)), 32'(mon_it.data));
                else           check("a_rdata", 32'(a_rdata), 32'(mon_it.data));
            end
        end
        if (b_done) begin
            if (q_b.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL b_unexpected_done: got done expected none (cycle %0d)", cyc);
            end else begin
                mon_it = q_b.pop_front();
                if (mon_it.we) check("b_write_mem", 32'(sram_rd(mon_it.addr)), 32'(mon_it.data));
                else           check("b_rdata", 32'(b_rdata), 32'(mon_it.data));
            end
        end
    end

    task automatic expect_item(input int p, input logic we, input logic [ADDR_W-1:0] ad,
                               input logic [DATA_W-1:0] wd);
        item_t it;
        it.we   = we;
        it.addr = ad;
        it.data = we ? wd : ref_rd(ad);
        if (we) ref_mem[ad] = wd;
        if (p == 0) q_a.push_back(it);
        else        q_b.push_back(it);
    endtask

    // Called #1 after a posedge; returns #1 after the posedge where done is seen.
    task automatic issue(input int p, input logic we, input logic [ADDR_W-1:0] ad,
                         input logic [DATA_W-1:0] wd, output int lat);
        int  c0;
        bit  got;
        expect_item(p, we, ad, wd);
        if (p == 0) begin a_we = we; a_addr = ad; a_wdata = wd; a_req = 1'b1; end
        else        begin b_we = we; b_addr = ad; b_wdata = wd; b_req = 1'b1; end
        c0  = cyc;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(posedge Clk); #1;
            got = (p == 0) ? a_done : b_done;
        end
        lat = cyc - c0;
        if (p == 0) a_req = 1'b0;
        else        b_req = 1'b0;
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: port %0d got no done expected within 30 cycles", p);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ord[4];
        int tdone[4];
        int nd, na, nb, ad0;

        // Reset and idle behaviour.
        repeat (3) @(posedge Clk);
        #1;
        check("reset_regs", 32'({sram_addr, sram_dq_out} | 36'(a_rdata) | 36'(b_rdata)), 32'd0);
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            check("idle_outputs", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, busy,
                                       a_done, b_done}), 32'h70);
        end

        // Single A read: exact latency and strobe width.
        sram_mem[20'h00010] = 16'h1234;
        ref_mem[20'h00010]  = 16'h1234;
        oe_lo = 0;
        nb    = b_done_cnt;
        issue(0, 1'b0, 20'h00010, 16'h0, lat);
        check("a_read_latency", 32'(lat), 32'(ACCESS_CYCLES + 1));
        check("a_read_oe_cycles", 32'(oe_lo), 32'(ACCESS_CYCLES));
        check("a_read_data", 32'(a_rdata), 32'h1234);
        check("b_done_quiet", 32'(b_done_cnt), 32'(nb));

        // B write then A readback.
        repeat (2) @(posedge Clk);
        #1;
        we_lo = 0; dqoe_hi = 0;
        issue(1, 1'b1, 20'h00200, 16'hBEEF, lat);
        check("b_write_we_cycles", 32'(we_lo), 32'(ACCESS_CYCLES));
        check("b_write_dqoe_cycles", 32'(dqoe_hi), 32'(ACCESS_CYCLES));
        check("b_write_bus_data", 32'(last_wdata), 32'hBEEF);
        issue(0, 1'b0, 20'h00200, 16'h0, lat);
        check("readback_data", 32'(a_rdata), 32'hBEEF);

        // Both requests held across reset release: alternating grants.
        Reset = 1'b1;
        a_we = 1'b0; a_addr = 20'h00500; b_we = 1'b0; b_addr = 20'h00600;
        a_req = 1'b1; b_req = 1'b1;
        repeat (2) begin
            expect_item(0, 1'b0, 20'h00500, 16'h0);
            expect_item(1, 1'b0, 20'h00600, 16'h0);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        nd = 0; na = 0; nb = 0;
        for (int i = 0; i < 60 && nd < 4; i++) begin
            @(posedge Clk); #1;
            if (a_done) begin ord[nd] = 0; tdone[nd] = cyc; nd++; na++; if (na == 2) a_req = 1'b0; end
            if (b_done) begin ord[nd] = 1; tdone[nd] = cyc; nd++; nb++; if (nb == 2) b_req = 1'b0; end
        end
        a_req = 1'b0; b_req = 1'b0;
        check("rr_done_count", 32'(nd), 32'd4);
        if (nd == 4) begin
            check("rr_order", 32'({ord[0][0], ord[1][0], ord[2][0], ord[3][0]}), 32'b0101);
            for (int i = 1; i < 4; i++)
                check("rr_spacing", 32'(tdone[i] - tdone[i-1]), 32'(ACCESS_CYCLES + 2));
        end

        // Reset in the second access cycle of an A write abandons it.
        repeat (2) @(posedge Clk);
        #1;
        ad0 = a_done_cnt;
        a_we = 1'b1; a_addr = 20'h00300; a_wdata = 16'h5555; a_req = 1'b1;
        repeat (2) begin @(posedge Clk); #1; end
        check("t5_in_access", 32'({busy, sram_we_n}), 32'b10);
        Reset = 1'b1; a_req = 1'b0;
        @(posedge Clk); #1;
        check("t5_strobes_off", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, busy}),
              32'b11100);
        Reset = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        check("t5_no_done", 32'(a_done_cnt), 32'(ad0));
        check("t5_mem_untouched", 32'(sram_rd(20'h00300)), 32'(dflt(20'h00300)));

        // Inputs changing mid-access do not disturb the granted address/data.
        expect_item(0, 1'b1, 20'h00400, 16'h1111);
        a_we = 1'b1; a_addr = 20'h00400; a_wdata = 16'h1111; a_req = 1'b1;
        @(posedge Clk); #1;
        a_addr = 20'h007FF; a_wdata = 16'h2222;
        repeat (2) begin
            @(posedge Clk); #1;
            check("t6_addr_hold", 32'(sram_addr), 32'h00400);
            check("t6_data_hold", 32'(sram_dq_out), 32'h1111);
        end
        @(posedge Clk); #1;
        check("t6_done", 32'(a_done), 32'd1);
        check("t6_addr_in_done", 32'(sram_addr), 32'h00400);
        a_req = 1'b0;
        repeat (2) @(posedge Clk);
        #1;

        // Random concurrent traffic, each port in its own address window.
        fork
            begin
                int la;
                for (int i = 0; i < 40; i++) begin
                    issue(0, 1'($urandom_range(0, 1)), 20'h01000 + 20'($urandom_range(0, 7)),
                          16'($urandom), la);
                    check("a_lat_min", 32'(la >= ACCESS_CYCLES + 1), 32'd1);
                    check("a_lat_max", 32'(la <= 2 * ACCESS_CYCLES + 6), 32'd1);
                    repeat ($urandom_range(0, 3)) begin @(posedge Clk); #1; end
                end
            end
            begin
                int lb;
                for (int i = 0; i < 40; i++) begin
                    issue(1, 1'($urandom_range(0, 1)), 20'h81000 + 20'($urandom_range(0, 7)),
                          16'($urandom), lb);
                    check("b_lat_min", 32'(lb >= ACCESS_CYCLES + 1), 32'd1);
                    check("b_lat_max", 32'(lb <= 2 * ACCESS_CYCLES + 6), 32'd1);
                    repeat ($urandom_range(0, 3)) begin @(posedge Clk); #1; end
                end
            end
        join

        repeat (10) @(posedge Clk);
        #1;
        check("q_a_drained", 32'(q_a.size()), 32'd0);
        check("q_b_drained", 32'(q_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
